ip_stim_driver: RTL and testbench

Self-checking stimulus source for the malformed-constraint test IP. It generates pseudo-random vectors on every input of the IP (data, range, bracket, valid and the two qualifier strobes) and compares the IP's three outputs against a golden model on each cycle. It reports a pass/fail verdict and a mismatch count per run. It sits beside the IP inside the test top, on the same clock; the IP's own reset is driven by the test top, not by this block.

---
 rtl/ip_stim_driver.sv | 171 +++++++++++++++++
 tb/tb_ip_stim_driver.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_stim_driver.sv
// Pseudo-random stimulus source and golden-model checker for the malformed-constraint test IP.
// Optional first-mismatch capture ports are enabled by defining STIM_FIRST_ERR_CAPTURE_EN.
module ip_stim_driver #(
    parameter int unsigned NUM_VECTORS = 16,
    parameter logic [31:0] LFSR_SEED   = 32'hC3A5_5A01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [7:0]  data_bus,
    output logic [7:0]  range_signal,
    output logic [15:0] bracket_signal,
    output logic        valid_signal,
    output logic        signal1,
    output logic        signal2,
    input  logic [7:0]  data_output,
    input  logic        valid_output,
    input  logic        test_output
`ifdef STIM_FIRST_ERR_CAPTURE_EN
    ,
    output logic [15:0] first_err_idx,
    output logic [7:0]  first_err_data
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_lfsr;
    logic [31:0] r_stim;
    logic [15:0] r_vec_idx;
    logic [15:0] r_err;
    logic        r_pass;
    logic        r_tmis;
    logic [7:0]  r_exp_data;
    logic        r_exp_valid;
    logic        r_exp_vld;
    logic        w_accept;
    logic        w_last;
    logic        w_load;
    logic [31:0] w_src;
    logic        w_mis;
    logic [15:0] w_err_next;
    logic        w_busy;
    logic        w_done;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {1'b0, l[31:1]} ^ (l[0] ? 32'h8020_0003 : 32'h0000_0000);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (r_vec_idx == LAST_IDX) w_next = S_DRAIN;
            S_DRAIN: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != S_IDLE);
        w_done = (r_state == S_DONE);
    end

    // r_lfsr always holds the state for the *next* vector; the start edge loads vector 0 straight from the seed.
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_state == S_RUN) && (r_vec_idx == LAST_IDX);
    assign w_load   = w_accept || ((r_state == S_RUN) && !w_last);
    assign w_src    = w_accept ? LFSR_SEED : r_lfsr;

    // Immediate test_output result is carried in r_tmis so one vector contributes at most one error.
    assign w_mis      = r_exp_vld && (r_tmis || (data_output != r_exp_data) || (valid_output != r_exp_valid));
    assign w_err_next = (w_mis && (r_err != '1)) ? r_err + 16'd1 : r_err;

    always_ff @(posedge clk) begin
        if (rst || w_last) begin
            r_stim <= '0;
        end else if (w_load) begin
            r_stim <= w_src;
        end
        if (rst)         r_lfsr <= LFSR_SEED;
        else if (w_load) r_lfsr <= lfsr_step(w_src);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec_idx   <= '0;
            r_err       <= '0;
            r_pass      <= 1'b0;
            r_tmis      <= 1'b0;
            r_exp_data  <= '0;
            r_exp_valid <= 1'b0;
            r_exp_vld   <= 1'b0;
        end else begin
            r_err <= w_accept ? '0 : w_err_next;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_vec_idx <= '0;
                        r_pass    <= 1'b0;
                        r_exp_vld <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_tmis      <= (test_output != (|bracket_signal));
                    r_exp_data  <= data_bus ^ range_signal;
                    r_exp_valid <= valid_signal & signal1 & signal2;
                    r_exp_vld   <= 1'b1;
                    r_vec_idx   <= r_vec_idx + 16'd1;
                end
                S_DRAIN: begin
                    r_exp_vld <= 1'b0;
                    r_pass    <= (w_err_next == '0);
                end
                default: ;
            endcase
        end
    end

`ifdef STIM_FIRST_ERR_CAPTURE_EN
    logic [15:0] r_exp_idx;
    logic        r_first_seen;
    logic [15:0] r_first_idx;
    logic [7:0]  r_first_data;

    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_exp_idx    <= '0;
            r_first_seen <= 1'b0;
            r_first_idx  <= '0;
            r_first_data <= '0;
        end else begin
            if (r_state == S_RUN) r_exp_idx <= r_vec_idx;
            if (w_mis && !r_first_seen) begin
                r_first_seen <= 1'b1;
                r_first_idx  <= r_exp_idx;
                r_first_data <= data_output;
            end
        end
    end

    assign first_err_idx  = r_first_idx;
    assign first_err_data = r_first_data;
`endif

    assign busy           = w_busy;
    assign done           = w_done;
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign data_bus       = r_stim[7:0];
    assign range_signal   = r_stim[15:8];
    assign bracket_signal = r_stim[31:16];
    assign valid_signal   = r_stim[16];
    assign signal1        = r_stim[24];
    assign signal2        = r_stim[29];

endmodule

// File: tb/tb_ip_stim_driver.sv
// Self-checking bench for ip_stim_driver: a behavioural IP model with injectable faults,
// a table of runs, and scoreboard queues of expected vectors and run results.
module tb_ip_stim_driver;

    localparam int unsigned NV   = 16;
    localparam logic [31:0] SEED = 32'hC3A5_5A01;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, start1;
    int   fault_mode;
    logic [31:0] v3_l;

    logic        busy, done, pass, valid_signal, signal1, signal2, valid_output, test_output;
    logic [15:0] err_count, bracket_signal;
    logic [7:0]  data_bus, range_signal, data_output;
    logic        busy1, done1, pass1, valid1, sig1_1, sig2_1, vout1, tout1;
    logic [15:0] err1, brk1;
    logic [7:0]  dbus1, rng1, dout1;
`ifdef STIM_FIRST_ERR_CAPTURE_EN
    logic [15:0] first_err_idx, fidx1;
    logic [7:0]  first_err_data, fdata1;
`endif

    ip_stim_driver #(.NUM_VECTORS(NV), .LFSR_SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .data_bus(data_bus), .range_signal(range_signal),
        .bracket_signal(bracket_signal), .valid_signal(valid_signal), .signal1(signal1),
        .signal2(signal2), .data_output(data_output), .valid_output(valid_output),
        .test_output(test_output)
`ifdef STIM_FIRST_ERR_CAPTURE_EN
        , .first_err_idx(first_err_idx), .first_err_data(first_err_data)
`endif
    );

    ip_stim_driver #(.NUM_VECTORS(1), .LFSR_SEED(SEED)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .data_bus(dbus1), .range_signal(rng1), .bracket_signal(brk1),
        .valid_signal(valid1), .signal1(sig1_1), .signal2(sig2_1), .data_output(dout1),
        .valid_output(vout1), .test_output(tout1)
`ifdef STIM_FIRST_ERR_CAPTURE_EN
        , .first_err_idx(fidx1), .first_err_data(fdata1)
`endif
    );

    // IP model: test_output combinational, data/valid registered; fault 1 flips bit 0 on vector 3, fault 2 sticks valid high
    logic [7:0] ip_d, ip_d1;
    logic       ip_v, ip_v1;
    always_ff @(posedge clk) begin
        if (fault_mode == 1 && {bracket_signal, range_signal, data_bus} == v3_l)
            ip_d <= (data_bus ^ range_signal) ^ 8'h01;
        else
            ip_d <= data_bus ^ range_signal;
        ip_v  <= valid_signal & signal1 & signal2;
        ip_d1 <= dbus1 ^ rng1;
        ip_v1 <= valid1 & sig1_1 & sig2_1;
    end
    assign data_output  = ip_d;
    assign valid_output = (fault_mode == 2) ? 1'b1 : ip_v;
    assign test_output  = |bracket_signal;
    assign dout1        = ip_d1;
    assign vout1        = ip_v1;
    assign tout1        = |brk1;

    typedef struct {
        logic [7:0]  d;
        logic [7:0]  r;
        logic [15:0] b;
        logic        v, s1, s2;
    } vec_t;

    typedef struct {
        logic [15:0] err;
        logic        pass;
        logic [15:0] fidx;
        logic [7:0]  fdata;
    } res_t;

    typedef struct {
        int mode;
        int restart_a;
        int restart_b;
        int rst_cyc;
        int exp_err;   // -1: take the count from the reference model
        int exp_pass;
        int chk_v0;
    } run_t;

    vec_t vec_q[$];
    res_t res_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [31:0] ref_step(input logic [31:0] l);
        logic [31:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ 32'h8020_0003;
        return n;
    endfunction

    function automatic vec_t ref_fields(input logic [31:0] l);
        vec_t f;
        f.d  = l[7:0];
        f.r  = l[15:8];
        f.b  = l[31:16];
        f.v  = l[16];
        f.s1 = l[24];
        f.s2 = l[29];
        return f;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_run(input run_t t);
        logic [31:0] l;
        vec_t        f, e;
        res_t        rs, got;
        logic        mis, exp_busy;
        int          dcnt, dcyc;
        fault_mode = t.mode;
        l = SEED;
        rs = '{err: '0, pass: 1'b0, fidx: '0, fdata: '0};
        for (int k = 0; k < int'(NV); k++) begin
            f = ref_fields(l);
            vec_q.push_back(f);
            mis = (t.mode == 1) ? (k == 3) : (t.mode == 2) ? !(f.v & f.s1 & f.s2) : 1'b0;
            if (mis) begin
                if (rs.err == 0) begin
                    rs.fidx  = 16'(k);
                    rs.fdata = (f.d ^ f.r) ^ ((t.mode == 1) ? 8'h01 : 8'h00);
                end
                rs.err++;
            end
            l = ref_step(l);
        end
        if (t.exp_err >= 0) rs.err = 16'(t.exp_err);
        rs.pass = (rs.err == 0);
        if (t.rst_cyc == 0) res_q.push_back(rs);

        @(negedge clk);
        start = 1'b1;
        dcnt = 0;
        dcyc = 0;
        for (int cyc = 1; cyc <= int'(NV) + 6; cyc++) begin
            @(negedge clk);
            if (cyc <= int'(NV) && (t.rst_cyc == 0 || cyc <= t.rst_cyc)) begin
                if (vec_q.size() == 0) begin
                    chk("vec_queue_empty", 64'd1, 64'd0);
                end else begin
                    e = vec_q.pop_front();
                    chk("stimulus", {data_bus, range_signal, bracket_signal, valid_signal, signal1, signal2},
                        {e.d, e.r, e.b, e.v, e.s1, e.s2});
                end
            end
            if (t.chk_v0 != 0 && cyc == 1) begin
                chk("vec0_fields", {bracket_signal, range_signal, data_bus}, 64'hC3A5_5A01);
                chk("vec0_flags", {valid_signal, signal1, signal2}, 64'b110);
            end
            exp_busy = (cyc <= int'(NV) + 2) && (t.rst_cyc == 0 || cyc <= t.rst_cyc);
            chk("busy", busy, exp_busy);
            if (t.rst_cyc != 0 && cyc == t.rst_cyc + 1)
                chk("outputs_after_rst",
                    {busy, done, pass, err_count, data_bus, range_signal, bracket_signal,
                     valid_signal, signal1, signal2}, 64'd0);
            if (done) begin
                dcnt++;
                dcyc = cyc;
                if (res_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    got = res_q.pop_front();
                    chk("err_count", err_count, got.err);
                    chk("pass_at_done", pass, got.pass);
`ifdef STIM_FIRST_ERR_CAPTURE_EN
                    chk("first_err_idx", first_err_idx, got.fidx);
                    chk("first_err_data", first_err_data, got.fdata);
`endif
                end
            end
            start = (cyc == t.restart_a) || (cyc == t.restart_b);
            rst   = (t.rst_cyc != 0) && (cyc == t.rst_cyc);
        end
        start = 1'b0;
        rst   = 1'b0;
        vec_q.delete();
        chk("done_count", 64'(dcnt), (t.rst_cyc == 0) ? 64'd1 : 64'd0);
        if (t.rst_cyc == 0) chk("done_cycle", 64'(dcyc), 64'(NV + 2));
        chk("pass_held", pass, 64'(t.exp_pass));
    endtask

    run_t runs [6];
    int   d1cnt;

    initial begin
        runs[0] = '{mode: 0, restart_a: 0, restart_b: 0,  rst_cyc: 0, exp_err: 0,  exp_pass: 1, chk_v0: 1};
        runs[1] = '{mode: 1, restart_a: 0, restart_b: 0,  rst_cyc: 0, exp_err: 1,  exp_pass: 0, chk_v0: 0};
        runs[2] = '{mode: 2, restart_a: 0, restart_b: 0,  rst_cyc: 0, exp_err: -1, exp_pass: 0, chk_v0: 0};
        runs[3] = '{mode: 0, restart_a: 5, restart_b: 18, rst_cyc: 0, exp_err: 0,  exp_pass: 1, chk_v0: 0};
        runs[4] = '{mode: 0, restart_a: 0, restart_b: 0,  rst_cyc: 7, exp_err: 0,  exp_pass: 0, chk_v0: 0};
        runs[5] = '{mode: 0, restart_a: 0, restart_b: 0,  rst_cyc: 0, exp_err: 0,  exp_pass: 1, chk_v0: 1};

        v3_l = ref_step(ref_step(ref_step(SEED)));
        fault_mode = 0;
        start  = 1'b0;
        start1 = 1'b0;
        rst    = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {busy, done, pass, err_count, data_bus, range_signal, bracket_signal,
             valid_signal, signal1, signal2}, 64'd0);
        chk("reset_outputs_n1", {busy1, done1, pass1, err1, dbus1, rng1, brk1}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) do_run(runs[i]);

        // NUM_VECTORS = 1: single vector, DRAIN check, done in cycle 3
        start1 = 1'b1;
        d1cnt = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (cyc == 1) chk("n1_vec0", {brk1, rng1, dbus1}, 64'hC3A5_5A01);
            if (cyc == 2) chk("n1_drain_zero", {brk1, rng1, dbus1}, 64'd0);
            chk("n1_busy", busy1, (cyc <= 3) ? 64'd1 : 64'd0);
            if (done1) begin
                d1cnt++;
                chk("n1_done_cycle", 64'(cyc), 64'd3);
                chk("n1_result", {pass1, err1}, {1'b1, 16'd0});
            end
        end
        chk("n1_done_count", 64'(d1cnt), 64'd1);
        chk("result_queue_drained", 64'(res_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
